// File: rtl/w_slave_fsm_pkg.sv
// Shared AXI definitions for the W-channel slave: datapath width, response
// encodings and the W-side FSM state type.
package w_slave_fsm_pkg;

  localparam int PIPE_DATA_WIDTH = 256;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_SLVERR = 2'b10
  } axi_resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  function automatic axi_resp_e resp_of(input logic err);
    return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/AXI4_W_IF.sv
// AXI4 write-data channel bundle; the slave modport receives beats and
// drives wready back.
interface AXI4_W_IF #(
  parameter int DATA_WIDTH = w_slave_fsm_pkg::PIPE_DATA_WIDTH
);
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;

  modport slave  (input wvalid, wdata, wstrb, wlast, output wready);
  modport master (output wvalid, wdata, wstrb, wlast, input wready);
endinterface

// File: rtl/w_slave_fsm.sv
// AXI4 write-data slave: accepts one burst command, forwards its beats into an
// external payload FIFO and returns a single B response per burst.
module w_slave_fsm
  import w_slave_fsm_pkg::*;
#(
  parameter int DATA_WIDTH = PIPE_DATA_WIDTH,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd_len,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  AXI4_W_IF.slave                 w_if,
  input  logic                    wr_fifo_full,
  output logic                    wr_fifo_wren,
  output logic [DATA_WIDTH-1:0]   wr_fifo_data,
  output logic [DATA_WIDTH/8-1:0] wr_fifo_strb,
  output logic                    wr_fifo_last,
  output logic                    b_valid,
  input  logic                    b_ready,
  output logic [ID_WIDTH-1:0]     b_id,
  output logic [1:0]              b_resp,
  output logic                    w_busy
);

  w_state_e            state;
  logic [7:0]          beat_cnt;
  logic [7:0]          len_q;
  logic [ID_WIDTH-1:0] id_q;
  logic                err_q;

  logic w_hs;
  logic count_hit;
  logic final_beat;
  logic last_mismatch;

  // Handshakes are masked while rst is high so nothing is accepted during
  // the reset cycle itself, even though the state register still holds its
  // pre-reset value.
  assign cmd_ready     = (state == W_IDLE) && !rst;
  assign w_if.wready   = (state == W_DATA) && !wr_fifo_full && !rst;
  assign w_busy        = (state != W_IDLE);

  assign w_hs          = w_if.wvalid && w_if.wready;
  assign count_hit     = (beat_cnt == len_q);
  assign final_beat    = w_if.wlast || count_hit;
  assign last_mismatch = w_if.wlast != count_hit;

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch reads pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= W_IDLE;
      beat_cnt     <= '0;
      len_q        <= '0;
      id_q         <= '0;
      err_q        <= 1'b0;
      wr_fifo_wren <= 1'b0;
      wr_fifo_last <= 1'b0;
      wr_fifo_data <= '0;
      wr_fifo_strb <= '0;
      b_valid      <= 1'b0;
      b_id         <= '0;
      b_resp       <= 2'b00;
    end else begin
      wr_fifo_wren <= 1'b0;
      wr_fifo_last <= 1'b0;

      case (state)
        W_IDLE: begin
          if (cmd_valid) begin
            len_q    <= cmd_len;
            id_q     <= cmd_id;
            beat_cnt <= '0;
            err_q    <= 1'b0;
            state    <= W_DATA;
          end
        end

        W_DATA: begin
          if (w_hs) begin
            wr_fifo_wren <= 1'b1;
            wr_fifo_data <= w_if.wdata;
            wr_fifo_strb <= w_if.wstrb;
            beat_cnt     <= beat_cnt + 8'd1;
            if (final_beat) begin
              // Early or missing wlast still ends the burst here; the
              // mismatch is reported through SLVERR rather than by
              // waiting for the "correct" last beat.
              wr_fifo_last <= 1'b1;
              err_q        <= err_q | last_mismatch;
              b_valid      <= 1'b1;
              b_id         <= id_q;
              b_resp       <= resp_of(err_q | last_mismatch);
              state        <= W_RESP;
            end
          end
        end

        W_RESP: begin
          if (b_ready) begin
            b_valid <= 1'b0;
            state   <= W_IDLE;
          end
        end

        default: state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_w_slave_fsm.sv
// Directed bench for w_slave_fsm: one task per scenario, FIFO pushes captured
// on the falling edge and compared against hand-built expected beat lists.
module tb_w_slave_fsm;

  localparam int DW  = 32;
  localparam int IDW = 4;

  typedef struct {
    logic [DW-1:0]   d;
    logic [DW/8-1:0] s;
    logic            l;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [7:0]     cmd_len;
  logic [IDW-1:0] cmd_id;
  logic           wr_fifo_full;
  logic           wr_fifo_wren;
  logic [DW-1:0]  wr_fifo_data;
  logic [DW/8-1:0] wr_fifo_strb;
  logic           wr_fifo_last;
  logic           b_valid;
  logic           b_ready;
  logic [IDW-1:0] b_id;
  logic [1:0]     b_resp;
  logic           w_busy;

  int passed = 0;
  int total  = 0;

  beat_t got[$];
  beat_t exp_q[$];

  AXI4_W_IF #(.DATA_WIDTH(DW)) w_bus ();

  w_slave_fsm #(.DATA_WIDTH(DW), .ID_WIDTH(IDW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_len      (cmd_len),
    .cmd_id       (cmd_id),
    .w_if         (w_bus),
    .wr_fifo_full (wr_fifo_full),
    .wr_fifo_wren (wr_fifo_wren),
    .wr_fifo_data (wr_fifo_data),
    .wr_fifo_strb (wr_fifo_strb),
    .wr_fifo_last (wr_fifo_last),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_id         (b_id),
    .b_resp       (b_resp),
    .w_busy       (w_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_fifo_wren === 1'b1) got.push_back('{wr_fifo_data, wr_fifo_strb, wr_fifo_last});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_cmd(input logic [7:0] len, input logic [IDW-1:0] id);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_len = len; cmd_id = id;
    for (int n = 0; n < 10 && !ok; n++) begin
      #1;
      if (cmd_ready === 1'b1) ok = 1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    total++;
    if (!ok) $display("FAIL cmd_accept id=%0d: cmd_ready got 0 for 10 cycles, required 1", id);
    else passed++;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [DW/8-1:0] s, input logic l);
    bit ok = 0;
    w_bus.wvalid = 1'b1; w_bus.wdata = d; w_bus.wstrb = s; w_bus.wlast = l;
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      if (w_bus.wready === 1'b1) ok = 1;
      @(negedge clk);
    end
    w_bus.wvalid = 1'b0; w_bus.wlast = 1'b0;
    total++;
    if (!ok) $display("FAIL beat_accept data=%h: wready got 0 for 20 cycles, required 1", d);
    else passed++;
  endtask

  task automatic check_pushes(input string name);
    int n;
    #1;
    total++;
    if (got.size() != exp_q.size())
      $display("FAIL %s push_count: got %0d required %0d", name, got.size(), exp_q.size());
    else passed++;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (got[i].d !== exp_q[i].d || got[i].s !== exp_q[i].s || got[i].l !== exp_q[i].l)
        $display("FAIL %s push[%0d]: got d=%h s=%h l=%b required d=%h s=%h l=%b", name, i,
                 got[i].d, got[i].s, got[i].l, exp_q[i].d, exp_q[i].s, exp_q[i].l);
      else passed++;
    end
  endtask

  task automatic finish_b(input logic [IDW-1:0] id, input logic [1:0] resp, input string name);
    for (int n = 0; n < 10; n++) begin
      if (b_valid === 1'b1) break;
      @(negedge clk);
    end
    total++;
    if (b_valid !== 1'b1) $display("FAIL %s b_valid: got %b required 1", name, b_valid); else passed++;
    total++;
    if (b_id !== id) $display("FAIL %s b_id: got %h required %h", name, b_id, id); else passed++;
    total++;
    if (b_resp !== resp) $display("FAIL %s b_resp: got %b required %b", name, b_resp, resp); else passed++;
    total++;
    if (cmd_ready !== 1'b0) $display("FAIL %s cmd_ready_in_resp: got %b required 0", name, cmd_ready); else passed++;
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    total++;
    if (b_valid !== 1'b0) $display("FAIL %s b_valid_after_hs: got %b required 0", name, b_valid); else passed++;
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL %s cmd_ready_after_hs: got %b required 1", name, cmd_ready); else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b0) $display("FAIL reset cmd_ready: got %b required 0", cmd_ready); else passed++;
    total++;
    if ({wr_fifo_wren, wr_fifo_last, b_valid, w_busy, w_bus.wready} !== 5'b0)
      $display("FAIL reset flags: got wren=%b last=%b b_valid=%b busy=%b wready=%b required all 0",
               wr_fifo_wren, wr_fifo_last, b_valid, w_busy, w_bus.wready);
    else passed++;
    total++;
    if ({wr_fifo_data, wr_fifo_strb, b_id, b_resp} !== '0)
      $display("FAIL reset data: got data=%h strb=%h b_id=%h b_resp=%b required all 0",
               wr_fifo_data, wr_fifo_strb, b_id, b_resp);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_release cmd_ready: got %b required 1", cmd_ready); else passed++;
  endtask

  task automatic test_basic();
    @(negedge clk);
    got.delete(); exp_q.delete();
    send_cmd(8'd3, 4'd5);
    for (int i = 0; i < 4; i++) begin
      send_beat(32'h1000_0000 + DW'(i), 4'hF ^ 4'(i), i == 3);
      exp_q.push_back('{32'h1000_0000 + DW'(i), 4'hF ^ 4'(i), i == 3});
    end
    finish_b(4'd5, 2'b00, "basic");
    check_pushes("basic");
  endtask

  task automatic test_early_wlast();
    @(negedge clk);
    got.delete(); exp_q.delete();
    send_cmd(8'd3, 4'd2);
    send_beat(32'h2000_0000, 4'h3, 1'b0);
    send_beat(32'h2000_0001, 4'hC, 1'b1);
    exp_q.push_back('{32'h2000_0000, 4'h3, 1'b0});
    exp_q.push_back('{32'h2000_0001, 4'hC, 1'b1});
    w_bus.wvalid = 1'b1; w_bus.wdata = 32'h2000_0002; w_bus.wstrb = 4'hF;
    #1;
    total++;
    if (w_bus.wready !== 1'b0) $display("FAIL early_wlast wready_in_resp: got %b required 0", w_bus.wready); else passed++;
    finish_b(4'd2, 2'b10, "early_wlast");
    total++;
    if (w_bus.wready !== 1'b0) $display("FAIL early_wlast wready_in_idle: got %b required 0", w_bus.wready); else passed++;
    @(negedge clk);
    w_bus.wvalid = 1'b0;
    check_pushes("early_wlast");
  endtask

  task automatic test_missing_wlast();
    @(negedge clk);
    got.delete(); exp_q.delete();
    send_cmd(8'd1, 4'd7);
    send_beat(32'h3000_0000, 4'h1, 1'b0);
    send_beat(32'h3000_0001, 4'h2, 1'b0);
    exp_q.push_back('{32'h3000_0000, 4'h1, 1'b0});
    exp_q.push_back('{32'h3000_0001, 4'h2, 1'b1});
    finish_b(4'd7, 2'b10, "missing_wlast");
    check_pushes("missing_wlast");
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    got.delete(); exp_q.delete();
    send_cmd(8'd7, 4'hA);
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{32'h4000_0000 + DW'(i * 3), 4'(i + 1), i == 7});
    for (int i = 0; i < 3; i++) send_beat(32'h4000_0000 + DW'(i * 3), 4'(i + 1), 1'b0);
    wr_fifo_full = 1'b1;
    w_bus.wvalid = 1'b1; w_bus.wdata = 32'h4000_0009; w_bus.wstrb = 4'h4;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (w_bus.wready !== 1'b0 || w_busy !== 1'b1)
        $display("FAIL backpressure stall%0d: got wready=%b busy=%b required wready=0 busy=1", c, w_bus.wready, w_busy);
      else passed++;
      @(negedge clk);
    end
    wr_fifo_full = 1'b0;
    for (int i = 3; i < 8; i++) send_beat(32'h4000_0000 + DW'(i * 3), 4'(i + 1), i == 7);
    finish_b(4'hA, 2'b00, "backpressure");
    check_pushes("backpressure");
  endtask

  task automatic test_b_stall();
    @(negedge clk);
    got.delete(); exp_q.delete();
    send_cmd(8'd0, 4'd9);
    send_beat(32'h5000_00AA, 4'h9, 1'b1);
    exp_q.push_back('{32'h5000_00AA, 4'h9, 1'b1});
    for (int c = 0; c < 5; c++) begin
      total++;
      if (b_valid !== 1'b1 || b_id !== 4'd9 || b_resp !== 2'b00 || cmd_ready !== 1'b0)
        $display("FAIL b_stall cycle%0d: got valid=%b id=%h resp=%b cmd_ready=%b required 1/9/00/0",
                 c, b_valid, b_id, b_resp, cmd_ready);
      else passed++;
      @(negedge clk);
    end
    finish_b(4'd9, 2'b00, "b_stall");
    check_pushes("b_stall");
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    got.delete(); exp_q.delete();
    send_cmd(8'd7, 4'd3);
    send_beat(32'h6000_0001, 4'h5, 1'b0);
    send_beat(32'h6000_0002, 4'hA, 1'b0);
    exp_q.push_back('{32'h6000_0001, 4'h5, 1'b0});
    exp_q.push_back('{32'h6000_0002, 4'hA, 1'b0});
    rst = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b0) $display("FAIL reset_mid cmd_ready_during_rst: got %b required 0", cmd_ready); else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1 || w_busy !== 1'b0)
      $display("FAIL reset_mid idle: got cmd_ready=%b busy=%b required 1/0", cmd_ready, w_busy);
    else passed++;
    total++;
    if (wr_fifo_wren !== 1'b0 || b_valid !== 1'b0 || wr_fifo_data !== '0 || wr_fifo_strb !== '0)
      $display("FAIL reset_mid outputs: got wren=%b b_valid=%b data=%h strb=%h required 0/0/0/0",
               wr_fifo_wren, b_valid, wr_fifo_data, wr_fifo_strb);
    else passed++;
    w_bus.wvalid = 1'b1; w_bus.wdata = 32'h6000_0003; w_bus.wstrb = 4'hF; w_bus.wlast = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (w_bus.wready !== 1'b0 || b_valid !== 1'b0)
        $display("FAIL reset_mid after%0d: got wready=%b b_valid=%b required 0/0", c, w_bus.wready, b_valid);
      else passed++;
    end
    w_bus.wvalid = 1'b0; w_bus.wlast = 1'b0;
    check_pushes("reset_mid");
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_id = '0;
    wr_fifo_full = 1'b0; b_ready = 1'b0;
    w_bus.wvalid = 1'b0; w_bus.wdata = '0; w_bus.wstrb = '0; w_bus.wlast = 1'b0;

    test_reset();
    test_basic();
    test_early_wlast();
    test_missing_wlast();
    test_backpressure();
    test_b_stall();
    test_reset_mid_burst();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
